vga_grid_scan: RTL and testbench



---
 rtl/vga_grid_scan.sv | 207 ++++++++++++++++++++
 tb/tb_vga_grid_scan.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_grid_scan.sv
// -----------------------------------------------------------------------------
// vga_grid_scan
//   VGA raster generator and cell scanner for the counter grid.
//   Produces 640x480@60 Hz timing from a 25 MHz pixel clock and divides the
//   active area into a GRID_COLS x GRID_ROWS grid of cells. The bank read
//   address follows the cell under the beam. The returned cell value is
//   registered into RGB together with the syncs, so all outputs share one
//   clock of latency.
//
//   Optional feature macro: GRID_LINES_EN
//     When defined, a 1-pixel white grid and frame is overlaid on the
//     active area. This covers the first pixel column and row of every cell,
//     plus the last active column and the last active line.
//
// Ports
//   clk    in   1         pixel clock (25 MHz)
//   rst    in   1         asynchronous active-low reset
//   datR   in   BIT_DATO  cell value from the bank (combinational on addrR)
//   addrR  out  BIT_ADDR  bank read address {cellRow, cellCol}
//   hsync  out  1         horizontal sync, active-low, registered
//   vsync  out  1         vertical sync, active-low, registered
//   vidOn  out  1         output pixel lies in the active area, registered
//   rgb    out  3         {R,G,B} pixel, registered
// -----------------------------------------------------------------------------
module vga_grid_scan #(
    parameter int BIT_ADDR = 4,
    parameter int BIT_DATO = 3,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIT_DATO-1:0] datR,
    output logic [BIT_ADDR-1:0] addrR,
    output logic                hsync,
    output logic                vsync,
    output logic                vidOn,
    output logic [2:0]          rgb
);

    localparam int HALF      = BIT_ADDR / 2;
    localparam int GRID_COLS = 2 ** HALF;
    localparam int GRID_ROWS = 2 ** HALF;
    localparam int CELL_W    = H_ACTIVE / GRID_COLS;
    localparam int CELL_H    = V_ACTIVE / GRID_ROWS;
    localparam int CW_BITS   = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int CH_BITS   = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sized copies of the timing constants, so every compare is width-matched
    localparam logic [9:0]         H_ACT_C    = 10'(H_ACTIVE);
    localparam logic [9:0]         H_LAST_C   = 10'(H_TOTAL - 1);
    localparam logic [9:0]         HS_FIRST_C = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]         HS_LAST_C  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]         V_ACT_C    = 10'(V_ACTIVE);
    localparam logic [9:0]         V_LAST_C   = 10'(V_TOTAL - 1);
    localparam logic [9:0]         VS_FIRST_C = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]         VS_LAST_C  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW_BITS-1:0] CX_LAST_C  = CW_BITS'(CELL_W - 1);
    localparam logic [CH_BITS-1:0] CY_LAST_C  = CH_BITS'(CELL_H - 1);
    localparam logic [HALF-1:0]    CELL_ONE_C = HALF'(1);

    logic [9:0]         r_hcnt;
    logic [9:0]         r_vcnt;
    logic [CW_BITS-1:0] r_cell_x;
    logic [CH_BITS-1:0] r_cell_y;
    logic [HALF-1:0]    r_cell_col;
    logic [HALF-1:0]    r_cell_row;
    logic [2:0]         r_rgb;
    logic               r_vid_on;
    logic               r_hsync;
    logic               r_vsync;

    logic               w_h_active;
    logic               w_v_active;
    logic               w_active;
    logic               w_line_end;
    logic               w_frame_end;
    logic               w_in_hsync;
    logic               w_in_vsync;
    logic [2:0]         w_pix;

    assign w_h_active  = (r_hcnt < H_ACT_C);
    assign w_v_active  = (r_vcnt < V_ACT_C);
    assign w_active    = w_h_active && w_v_active;
    assign w_line_end  = (r_hcnt == H_LAST_C);
    assign w_frame_end = (r_vcnt == V_LAST_C);
    assign w_in_hsync  = (r_hcnt >= HS_FIRST_C) && (r_hcnt <= HS_LAST_C);
    assign w_in_vsync  = (r_vcnt >= VS_FIRST_C) && (r_vcnt <= VS_LAST_C);

    // Pixel and line counters: hcnt wraps each line, vcnt advances at line end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcnt <= 10'd0;
            r_vcnt <= 10'd0;
        end else if (w_line_end) begin
            r_hcnt <= 10'd0;
            if (w_frame_end) begin
                r_vcnt <= 10'd0;
            end else begin
                r_vcnt <= r_vcnt + 10'd1;
            end
        end else begin
            r_hcnt <= r_hcnt + 10'd1;
        end
    end

    // Horizontal cell tracking; the column wraps naturally after the last cell
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cell_x   <= {CW_BITS{1'b0}};
            r_cell_col <= {HALF{1'b0}};
        end else if (w_line_end) begin
            r_cell_x   <= {CW_BITS{1'b0}};
            r_cell_col <= {HALF{1'b0}};
        end else if (w_h_active) begin
            if (r_cell_x == CX_LAST_C) begin
                r_cell_x   <= {CW_BITS{1'b0}};
                r_cell_col <= r_cell_col + CELL_ONE_C;
            end else begin
                r_cell_x   <= r_cell_x + CW_BITS'(1);
            end
        end else begin
            r_cell_x   <= r_cell_x;
            r_cell_col <= r_cell_col;
        end
    end

    // Vertical cell tracking, stepped once per line and cleared at frame end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cell_y   <= {CH_BITS{1'b0}};
            r_cell_row <= {HALF{1'b0}};
        end else if (w_line_end && w_frame_end) begin
            r_cell_y   <= {CH_BITS{1'b0}};
            r_cell_row <= {HALF{1'b0}};
        end else if (w_line_end && w_v_active) begin
            if (r_cell_y == CY_LAST_C) begin
                r_cell_y   <= {CH_BITS{1'b0}};
                r_cell_row <= r_cell_row + CELL_ONE_C;
            end else begin
                r_cell_y   <= r_cell_y + CH_BITS'(1);
            end
        end else begin
            r_cell_y   <= r_cell_y;
            r_cell_row <= r_cell_row;
        end
    end

    // Bank address for the cell under the beam; blanking parks it predictably
    always_comb begin
        addrR = {BIT_ADDR{1'b0}};
        if (!w_v_active) begin
            addrR = {BIT_ADDR{1'b0}};
        end else if (!w_h_active) begin
            addrR = {r_cell_row, {HALF{1'b0}}};
        end else begin
            addrR = {r_cell_row, r_cell_col};
        end
    end

`ifdef GRID_LINES_EN
    logic w_grid_line;
    assign w_grid_line = (r_cell_x == {CW_BITS{1'b0}}) || (r_cell_y == {CH_BITS{1'b0}}) ||
                         (r_hcnt == 10'(H_ACTIVE - 1)) || (r_vcnt == 10'(V_ACTIVE - 1));
`endif

    // Pixel colour before the output register: bank data, optionally overlaid
    always_comb begin
        w_pix = datR;
`ifdef GRID_LINES_EN
        if (w_grid_line) begin
            w_pix = 3'b111;
        end else begin
            w_pix = datR;
        end
`endif
    end

    // Output register stage keeps rgb, vidOn and both syncs mutually aligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb    <= 3'b000;
            r_vid_on <= 1'b0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
        end else begin
            r_rgb    <= w_active ? w_pix : 3'b000;
            r_vid_on <= w_active;
            r_hsync  <= !w_in_hsync;
            r_vsync  <= !w_in_vsync;
        end
    end

    assign rgb   = r_rgb;
    assign vidOn = r_vid_on;
    assign hsync = r_hsync;
    assign vsync = r_vsync;

endmodule

// File: tb/tb_vga_grid_scan.sv
// -----------------------------------------------------------------------------
// tb_vga_grid_scan
//   Bench for vga_grid_scan, run with a reduced raster so that several whole
//   frames fit in a short run. The 4x4 grid and the timing rules are the same
//   as in the full-size raster; only the pixel and line counts are scaled.
//   A reference model derives position, address and pixel colour from the
//   cycle count with plain division. A scoreboard compares every cycle.
//   A constant vector table and hand-written sequences cover the reset,
//   address, data-path, live-update and sync corner cases.
// -----------------------------------------------------------------------------
module tb_vga_grid_scan;

    localparam int HA = 40, HFP = 4, HS = 6, HB = 6;
    localparam int VA = 24, VFP = 2, VS = 2, VB = 3;
    localparam int HT = HA + HFP + HS + HB;   // 56
    localparam int VT = VA + VFP + VS + VB;   // 31
    localparam int FRAME = HT * VT;           // 1736
    localparam int GC = 4;
    localparam int CW = HA / GC;              // 10
    localparam int CH = VA / GC;              // 6
`ifdef GRID_LINES_EN
    localparam bit GL = 1'b1;
`else
    localparam bit GL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] datR;
    logic [3:0] addrR;
    logic       hsync, vsync, vidOn;
    logic [2:0] rgb;
    logic [2:0] bank [16];

    int n;            // posedges since reset release (written by main only)
    bit sb_en;
    int checks;
    int failures;

    always #20 clk = ~clk;

    // Bank model: combinational read of the cell store
    assign datR = bank[addrR];

    vga_grid_scan #(
        .BIT_ADDR(4), .BIT_DATO(3),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .datR (datR),
        .addrR(addrR),
        .hsync(hsync),
        .vsync(vsync),
        .vidOn(vidOn),
        .rgb  (rgb)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, n);
        end
    endtask

    // Reference: bank address for beam position (h,v)
    function automatic int exp_addr(input int h, input int v);
        if (v >= VA) return 0;
        if (h >= HA) return (v / CH) * GC;
        return (v / CH) * GC + h / CW;
    endfunction

    // Reference: displayed colour for pixel (h,v) given the bank value d
    function automatic int exp_rgb(input int h, input int v, input int d);
        if (!(h < HA && v < VA)) return 0;
        if (GL && ((h % CW) == 0 || (v % CH) == 0 || h == HA - 1 || v == VA - 1)) return 7;
        return d;
    endfunction

    function automatic int exp_hsync(input int h);
        return (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1;
    endfunction

    function automatic int exp_vsync(input int v);
        return (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1;
    endfunction

    // Per-cycle scoreboard: address of the current position, outputs of the previous one
    int sb_c, sb_h, sb_v, sb_p, sb_ph, sb_pv;
    always @(negedge clk) begin
        if (sb_en) begin
            sb_c = n % FRAME;
            sb_h = sb_c % HT;
            sb_v = sb_c / HT;
            check("sb_addrR", int'(addrR), exp_addr(sb_h, sb_v));
            if (n > 0) begin
                sb_p  = (n - 1) % FRAME;
                sb_ph = sb_p % HT;
                sb_pv = sb_p / HT;
                check("sb_vidOn", int'(vidOn), (sb_ph < HA && sb_pv < VA) ? 1 : 0);
                check("sb_hsync", int'(hsync), exp_hsync(sb_ph));
                check("sb_vsync", int'(vsync), exp_vsync(sb_pv));
                check("sb_rgb", int'(rgb),
                      exp_rgb(sb_ph, sb_pv, int'(bank[exp_addr(sb_ph, sb_pv)])));
            end
        end
    end

    task automatic tick_to(input int target);
        while (n < target) begin
            @(posedge clk);
            n = n + 1;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"},   int'(rgb),   0);
        check({tag, "_hsync"}, int'(hsync), 1);
        check({tag, "_vsync"}, int'(vsync), 1);
        check({tag, "_vidOn"}, int'(vidOn), 0);
        check({tag, "_addrR"}, int'(addrR), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #5;
        rst   = 1'b1;
        n     = 0;
        sb_en = 1'b1;
    endtask

    typedef struct {
        int         h;
        int         v;
        logic [3:0] addr;
        logic       vid;
        logic [2:0] rgb;
    } vec_t;

    vec_t tbl[8];
    int   cnt, first, prev, fall0, fall1, base;

    initial begin
        checks   = 0;
        failures = 0;
        n        = 0;
        sb_en    = 1'b0;
        rst      = 1'b0;
        for (int i = 0; i < 16; i++) bank[i] = 3'(i);

        // Vectors sorted by raster position; rgb/vid are for the pixel one clock later
        tbl[0] = '{0,  0,  4'd0,  1'b1, GL ? 3'd7 : 3'd0};
        tbl[1] = '{10, 0,  4'd1,  1'b1, GL ? 3'd7 : 3'd1};
        tbl[2] = '{29, 0,  4'd2,  1'b1, GL ? 3'd7 : 3'd2};
        tbl[3] = '{11, 1,  4'd1,  1'b1, 3'd1};
        tbl[4] = '{0,  6,  4'd4,  1'b1, GL ? 3'd7 : 3'd4};
        tbl[5] = '{50, 8,  4'd4,  1'b0, 3'd0};
        tbl[6] = '{39, 23, 4'd15, 1'b1, 3'd7};
        tbl[7] = '{20, 27, 4'd0,  1'b0, 3'd0};

        // Power-on reset
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        release_reset();

        // Address scan and data path from the vector table
        for (int i = 0; i < 8; i++) begin
            tick_to(tbl[i].v * HT + tbl[i].h);
            check($sformatf("tbl%0d_addrR", i), int'(addrR), int'(tbl[i].addr));
            tick_to(n + 1);
            check($sformatf("tbl%0d_vidOn", i), int'(vidOn), int'(tbl[i].vid));
            check($sformatf("tbl%0d_rgb", i),   int'(rgb),   int'(tbl[i].rgb));
        end

        // Live update of cell 5 in the middle of line 9 of frame 2
        tick_to(FRAME + 9 * HT + 13);
        check("live_old", int'(rgb), 5);
        tick_to(FRAME + 9 * HT + 15);
        #5 bank[5] = 3'd6;
        tick_to(FRAME + 9 * HT + 17);
        check("live_new", int'(rgb), 6);
        tick_to(FRAME + 10 * HT + 13);
        check("live_next_line", int'(rgb), 6);

        // hsync: low length and position within one line
        tick_to(FRAME + 12 * HT + 1);
        cnt   = 0;
        first = -1;
        for (int k = 0; k < HT; k++) begin
            if (!hsync) begin
                cnt++;
                if (first < 0) first = k;
            end
            tick_to(n + 1);
        end
        check("hsync_low_len", cnt, HS);
        check("hsync_fall_pix", first, HA + HFP);

        // vsync: low length per frame and frame period
        tick_to(2 * FRAME + 1);
        cnt   = 0;
        prev  = 1;
        fall0 = -1;
        fall1 = -1;
        for (int k = 0; k < FRAME + (VA + VFP + 1) * HT; k++) begin
            if (k < FRAME && !vsync) cnt++;
            if (prev == 1 && vsync == 1'b0) begin
                if (fall0 < 0) fall0 = k;
                else if (fall1 < 0) fall1 = k;
            end
            prev = int'(vsync);
            tick_to(n + 1);
        end
        check("vsync_low_clk", cnt, VS * HT);
        check("vsync_fall_pix", fall0, (VA + VFP) * HT);
        check("frame_period", fall1 - fall0, FRAME);

        // Randomised bank writes over two frames; scoreboard checks each pixel
        base = n + 2 * FRAME;
        while (n < base) begin
            tick_to(n + 1);
            if ($urandom_range(7, 0) == 0) begin
                #5 bank[$urandom_range(15, 0)] = 3'($urandom);
            end
        end

        // Reset mid-frame while both syncs are low
        tick_to(((n / FRAME) + 1) * FRAME + (VA + VFP) * HT + HA + HFP + 2);
        check("pre_rst_hsync", int'(hsync), 0);
        check("pre_rst_vsync", int'(vsync), 0);
        #5;
        sb_en = 1'b0;
        rst   = 1'b0;
        #2 check_reset_outputs("rst_sync");
        @(negedge clk);
        check_reset_outputs("rst_hold");
        release_reset();
        tick_to(3 * HT);

        // Reset mid-frame during an active, coloured pixel
        for (int i = 0; i < 16; i++) bank[i] = 3'(i);
        tick_to(9 * HT + 16);
        check("pre_rst2_vidOn", int'(vidOn), 1);
        check("pre_rst2_rgb", int'(rgb), 5);
        #5;
        sb_en = 1'b0;
        rst   = 1'b0;
        #2 check_reset_outputs("rst_active");
        release_reset();
        tick_to(HT + 5);

`ifdef GRID_LINES_EN
        // Grid overlay with an all-black bank
        #5 for (int i = 0; i < 16; i++) bank[i] = 3'd0;
        tick_to(FRAME + 2 * HT + 39 + 1);
        check("grid_right_edge", int'(rgb), 7);
        tick_to(FRAME + 3 * HT + 0 + 1);
        check("grid_left_col", int'(rgb), 7);
        tick_to(FRAME + 3 * HT + 5 + 1);
        check("grid_inside", int'(rgb), 0);
        tick_to(FRAME + 5 * HT + 10 + 1);
        check("grid_cell_col", int'(rgb), 7);
        tick_to(FRAME + 6 * HT + 7 + 1);
        check("grid_cell_row", int'(rgb), 7);
`endif

        tick_to(n + 2 * HT);
        sb_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
